// File: rtl/vslide_stream.sv
// Vector slide engine: byte-granular vslideup/vslidedown and vslide1up/vslide1down
// over a valid/ready stream of register-group beats, two register stages deep.
module vslide_stream #(
   parameter int DATA_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 32,
   parameter int OFF_WIDTH    = 12,
   parameter int SCALAR_WIDTH = 64,
   parameter int BE_WIDTH     = DATA_WIDTH / 8,
   parameter int SHIFT_WIDTH  = $clog2(BE_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_vec,
   input  logic [SCALAR_WIDTH-1:0] in_scalar,
   input  logic [1:0]              in_sew,
   input  logic [SHIFT_WIDTH-1:0]  in_shift,
   input  logic                    in_start,
   input  logic                    in_end,
   input  logic                    in_opSel,
   input  logic                    in_insert,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic [BE_WIDTH-1:0]     in_be,
   input  logic [OFF_WIDTH-1:0]    in_off,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_vec,
   output logic [BE_WIDTH-1:0]     out_be,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic [OFF_WIDTH-1:0]    out_off,
   output logic                    busy
);

   typedef enum logic { MODE_UP = 1'b0, MODE_DOWN = 1'b1 } mode_e;

   localparam int BIT_SH_W = SHIFT_WIDTH + 4;

   // Group configuration, captured on the accepted start beat.
   mode_e                   cfg_mode;
   logic                    cfg_insert;
   logic [SHIFT_WIDTH-1:0]  cfg_shift;
   logic [SCALAR_WIDTH-1:0] cfg_scalar;

   logic                    s1_valid;
   logic                    s1_start;
   logic                    s1_end;
   logic [DATA_WIDTH-1:0]   s1_vec;
   logic [BE_WIDTH-1:0]     s1_be;
   logic [ADDR_WIDTH-1:0]   s1_addr;
   logic [OFF_WIDTH-1:0]    s1_off;
   logic [DATA_WIDTH-1:0]   prev_vec;
   logic                    s2_valid;

   logic                    s2_free;
   logic                    lookahead_ok;
   logic                    s1_adv;
   logic                    accept;
   logic [BIT_SH_W-1:0]     bit_sh;
   logic [BIT_SH_W-1:0]     bit_inv;
   logic [DATA_WIDTH-1:0]   scalar_lo;
   logic [DATA_WIDTH-1:0]   up_carry;
   logic [DATA_WIDTH-1:0]   down_fill;
   logic [DATA_WIDTH-1:0]   slid_vec;
   logic [BE_WIDTH-1:0]     slid_be;
   logic [OFF_WIDTH-1:0]    slid_off;
   logic                    unused_sew;

   // Down mode needs beat k+1 (or the end marker) before beat k can leave S1.
   assign s2_free      = ~s2_valid | out_ready;
   assign lookahead_ok = (cfg_mode == MODE_UP) | s1_end | in_valid;
   assign s1_adv       = s1_valid & s2_free & lookahead_ok;
   assign in_ready     = rst & (~s1_valid | s1_adv);
   assign accept       = in_valid & in_ready;
   assign out_valid    = s2_valid;
   assign busy         = s1_valid | s2_valid;

   // Element width does not change the byte arithmetic; the shift alone decides.
   assign unused_sew   = ^in_sew;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      bit_sh    = {1'b0, cfg_shift, 3'b000};
      bit_inv   = BIT_SH_W'(DATA_WIDTH) - bit_sh;
      scalar_lo = DATA_WIDTH'(cfg_scalar) & ~({DATA_WIDTH{1'b1}} << bit_sh);
      up_carry  = '0;
      down_fill = '0;
      slid_vec  = '0;
      slid_be   = s1_be;
      slid_off  = s1_off;
      if (cfg_mode == MODE_UP) begin
         if (s1_start)
            up_carry = cfg_insert ? scalar_lo : '0;
         else
            up_carry = prev_vec >> bit_inv;
         slid_vec = (s1_vec << bit_sh) | up_carry;
         if (s1_start && !cfg_insert)
            slid_be = s1_be & ({BE_WIDTH{1'b1}} << cfg_shift);
      end else begin
         // A new start beat as lookahead means the old group ended without an end flag.
         if (s1_end)
            down_fill = cfg_insert ? (scalar_lo << bit_inv) : '0;
         else if (!in_start)
            down_fill = in_vec << bit_inv;
         slid_vec = (s1_vec >> bit_sh) | down_fill;
         slid_off = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: datapath registers are reset too, so reset discards carry and every beat at once.
      if (!rst) begin
         s1_valid   <= 1'b0;
         s1_start   <= 1'b0;
         s1_end     <= 1'b0;
         s1_vec     <= '0;
         s1_be      <= '0;
         s1_addr    <= '0;
         s1_off     <= '0;
         prev_vec   <= '0;
         cfg_mode   <= MODE_UP;
         cfg_insert <= 1'b0;
         cfg_shift  <= '0;
         cfg_scalar <= '0;
      end else begin
         // NOTE: non-blocking updates let S2 compute from the pre-edge S1 and config.
         if (accept) begin
            s1_valid <= 1'b1;
            s1_start <= in_start;
            s1_end   <= in_end;
            s1_vec   <= in_vec;
            s1_be    <= in_be;
            s1_addr  <= in_addr;
            s1_off   <= in_off;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
         if (accept && in_start) begin
            cfg_mode   <= mode_e'(in_opSel);
            cfg_insert <= in_insert;
            cfg_shift  <= in_shift;
            cfg_scalar <= in_scalar;
         end
         if (s1_adv)
            prev_vec <= s1_vec;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         out_vec  <= '0;
         out_be   <= '0;
         out_addr <= '0;
         out_off  <= '0;
      end else if (s1_adv) begin
         s2_valid <= 1'b1;
         out_vec  <= slid_vec;
         out_be   <= slid_be;
         out_addr <= s1_addr;
         out_off  <= slid_off;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule
